vmem0_ctl: RTL and testbench

Access controller for the level-0 virtual memory map RAM (2048 x 5). It sits between the CPU map datapath and the single-port map RAM. After reset or on command, it sweeps the whole map to a known value. It arbitrates CPU map reads and writes against an optional host debug port, and it drives the RAM enable, write-enable, address and write-data lines.

---
 rtl/vmem0_ctl.sv | 141 ++++++++++++++
 tb/tb_vmem0_ctl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vmem0_ctl.sv
// rtl/vmem0_ctl.sv - level-0 map RAM access controller: clear sweep, CPU/debug arbitration
// Debug port is built only when VMEM0_DBG_PORT_EN is defined.

module vmem0_ctl #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = DATA_WIDTH'(5'h1f),
  parameter int unsigned DBG_MAX_WAIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [ADDR_WIDTH-1:0] cpu_adr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_stall,
  output logic [DATA_WIDTH-1:0] cpu_vmap,
  input  logic                  clear_req,
  output logic                  busy,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_adr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_ack,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_adr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  cpu_act;
  logic                  dbg_grant;

  assign cpu_act   = cpu_rd | cpu_wr;
  assign busy      = (state_q == ST_CLEAR);
  assign cpu_stall = busy | (dbg_grant & cpu_act);
  assign cpu_vmap  = ram_rdata;

  // Reset lands in CLEAR with the counter at 0 so a sweep follows every reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          cnt_q <= cnt_q + ADDR_WIDTH'(1);
          if (&cnt_q) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (clear_req) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
          end
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

`ifdef VMEM0_DBG_PORT_EN
  localparam int unsigned WAIT_W = (DBG_MAX_WAIT < 1) ? 1 : $clog2(DBG_MAX_WAIT + 1);

  logic                  dbg_pend_q, dbg_pend_d;
  logic [1:0]            ack_sr_q, ack_sr_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
  logic                  dbg_force;

  assign dbg_force = (wait_q == WAIT_W'(DBG_MAX_WAIT));
  assign dbg_grant = (state_q == ST_IDLE) & dbg_req & ~dbg_pend_q & (~cpu_act | dbg_force);

  // The ack pipeline runs independently of the FSM, so a clear_req cannot drop an in-flight ack.
  always_comb begin
    ack_sr_d    = {ack_sr_q[0], dbg_grant};
    dbg_pend_d  = dbg_grant | (dbg_pend_q & ~ack_sr_q[1]);
    dbg_rdata_d = ack_sr_q[0] ? ram_rdata : dbg_rdata_q;
    wait_d      = wait_q;
    if (dbg_grant)
      wait_d = '0;
    else if (dbg_req & ~dbg_pend_q & ~dbg_force)
      wait_d = wait_q + WAIT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbg_pend_q  <= 1'b0;
      ack_sr_q    <= '0;
      wait_q      <= '0;
      dbg_rdata_q <= '0;
    end else begin
      dbg_pend_q  <= dbg_pend_d;
      ack_sr_q    <= ack_sr_d;
      wait_q      <= wait_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign dbg_ack   = ack_sr_q[1];
  assign dbg_rdata = dbg_rdata_q;
`else
  logic unused_dbg;

  assign unused_dbg = ^{dbg_req, dbg_we, dbg_adr, dbg_wdata, (DBG_MAX_WAIT != 0)};
  assign dbg_grant  = 1'b0;
  assign dbg_ack    = 1'b0;
  assign dbg_rdata  = '0;
`endif

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_adr   = cpu_adr;
    ram_wdata = cpu_wdata;
    if (busy) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_adr   = cnt_q;
      ram_wdata = CLEAR_VALUE;
    end else if (dbg_grant) begin
      ram_en    = 1'b1;
      ram_we    = dbg_we;
      ram_adr   = dbg_adr;
      ram_wdata = dbg_wdata;
    end else if (cpu_act) begin
      ram_en    = 1'b1;
      ram_we    = cpu_wr;
    end
    if (reset) begin
      ram_en = 1'b0;
      ram_we = 1'b0;
    end
  end

endmodule

// File: tb/tb_vmem0_ctl.sv
// tb/tb_vmem0_ctl.sv - scoreboard bench for vmem0_ctl with a read-first single-port RAM model
// Debug-port scenarios are selected by VMEM0_DBG_PORT_EN, matching the design build.

module tb_vmem0_ctl;
  localparam int AW = 11;
  localparam int DW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [AW-1:0] cpu_adr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_stall;
  logic [DW-1:0] cpu_vmap;
  logic          clear_req = 1'b0;
  logic          busy;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] dbg_adr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_adr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] dbg_q[$];
  logic          rd_prev = 1'b0;
  int            checks = 0;
  int            failures = 0;

  vmem0_ctl dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_vmap(cpu_vmap),
    .clear_req(clear_req), .busy(busy),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_adr(ram_adr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Read-first RAM: a write cycle returns the previous contents.
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_adr];
      if (ram_we) mem[ram_adr] <= ram_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_prev) begin
      if (rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL cpu_vmap_unexpected: got %0h expected no read", cpu_vmap);
      end else begin
        chk("cpu_vmap", 32'(cpu_vmap), 32'(rd_q.pop_front()));
      end
    end
    rd_prev = cpu_rd & ~cpu_stall & ~reset;
    if (dbg_ack) begin
      if (dbg_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dbg_ack_unexpected: got ack expected none");
      end else begin
        chk("dbg_rdata", 32'(dbg_rdata), 32'(dbg_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sweep(input string name);
    int n = 0;
    while (busy && n < 3000) begin
      n++;
      step();
    end
    chk(name, n, 2048);
  endtask

  task automatic wait_ack(input string name);
    int n = 0;
    while (!dbg_ack && n < 10) begin
      step();
      n++;
    end
    chk(name, n, 2);
  endtask

  logic [AW-1:0] tbl_adr [3] = '{11'h010, 11'h011, 11'h012};
  logic [DW-1:0] tbl_dat [3] = '{5'h01, 5'h02, 5'h1e};

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

    repeat (3) step();
    chk("rst_busy", busy, 1);
    chk("rst_stall", cpu_stall, 1);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_adr", ram_adr, 0);
    chk("rst_ram_wdata", ram_wdata, 5'h1f);
    chk("rst_dbg_ack", dbg_ack, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);

    reset = 1'b0;
    #1;
    chk("sweep_ram_we", ram_we, 1);
    wait_sweep("sweep_len_reset");
    chk("idle_stall", cpu_stall, 0);

    for (int a = 0; a < (1 << AW); a++) begin
      cpu_rd = 1'b1;
      cpu_adr = AW'(a);
      rd_q.push_back(5'h1f);
      step();
    end
    cpu_rd = 1'b0;
    step();

    cpu_wr = 1'b1; cpu_adr = 11'h7ff; cpu_wdata = 5'h0a;
    step();
    cpu_wr = 1'b0; cpu_rd = 1'b1; rd_q.push_back(5'h0a);
    step();
    cpu_wr = 1'b1; cpu_wdata = 5'h03; rd_q.push_back(5'h0a);
    #1;
    chk("rdwr_ram_we", ram_we, 1);
    step();
    cpu_wr = 1'b0; rd_q.push_back(5'h03);
    step();
    cpu_rd = 1'b0;

    for (int i = 0; i < 3; i++) begin
      cpu_wr = 1'b1; cpu_adr = tbl_adr[i]; cpu_wdata = tbl_dat[i];
      step();
    end
    cpu_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_rd = 1'b1; cpu_adr = tbl_adr[i]; rd_q.push_back(tbl_dat[i]);
      step();
    end
    cpu_rd = 1'b0;
    step();

`ifdef VMEM0_DBG_PORT_EN
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_adr = 11'h123; dbg_wdata = 5'h15;
    dbg_q.push_back(5'h1f);
    #1;
    chk("dbgw_ram_we", ram_we, 1);
    chk("dbgw_ram_adr", ram_adr, 11'h123);
    chk("dbgw_stall", cpu_stall, 0);
    wait_ack("dbgw_ack_lat");
    dbg_req = 1'b0;
    step();
    dbg_req = 1'b1; dbg_we = 1'b0;
    dbg_q.push_back(5'h15);
    wait_ack("dbgr_ack_lat");
    dbg_req = 1'b0;
    step();

    dbg_q.push_back(5'h03);
    cpu_rd = 1'b1; cpu_adr = 11'h000;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_adr = 11'h7ff;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("starve_stall", cpu_stall, (i == 15));
      if (i != 15) rd_q.push_back(5'h1f);
      step();
    end
    chk("starve_ack_g1", dbg_ack, 0);
    rd_q.push_back(5'h1f);
    step();
    chk("starve_ack_g2", dbg_ack, 1);
    rd_q.push_back(5'h1f);
    step();
    cpu_rd = 1'b0; dbg_req = 1'b0;
    step();
`else
    for (int i = 0; i < 10; i++) begin
      dbg_req = i[0]; dbg_we = 1'b1; dbg_adr = 11'h005; dbg_wdata = 5'h00;
      cpu_rd = i[1]; cpu_adr = 11'h000;
      if (i[1]) rd_q.push_back(5'h1f);
      #1;
      chk("nodbg_ack", dbg_ack, 0);
      chk("nodbg_stall", cpu_stall, 0);
      chk("nodbg_rdata", dbg_rdata, 0);
      step();
    end
    dbg_req = 1'b0; cpu_rd = 1'b0;
    step();
`endif

    clear_req = 1'b1; cpu_wr = 1'b1; cpu_adr = 11'h005; cpu_wdata = 5'h07;
    step();
    clear_req = 1'b0; cpu_wr = 1'b0;
    chk("clr_same_cycle_wr", mem[5], 5'h07);
    chk("clr_busy", busy, 1);
    wait_sweep("sweep_len_clear");
    cpu_rd = 1'b1; cpu_adr = 11'h005; rd_q.push_back(5'h1f);
    step();
    cpu_adr = 11'h7ff; rd_q.push_back(5'h1f);
    step();
    cpu_rd = 1'b0;
    step();

    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (1000) step();
    chk("mid_sweep_adr", ram_adr, 1000);
    reset = 1'b1;
    #1;
    chk("mid_rst_ram_en", ram_en, 0);
    step();
    reset = 1'b0;
    #1;
    chk("restart_adr", ram_adr, 0);
    wait_sweep("sweep_len_restart");
    cpu_rd = 1'b1; cpu_adr = 11'h010; rd_q.push_back(5'h1f);
    step();
    cpu_rd = 1'b0;
    repeat (3) step();

    chk("rd_q_empty", rd_q.size(), 0);
    chk("dbg_q_empty", dbg_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
